// File: rtl/mdu_pkg.sv
// Shared multiply/divide definitions: op encodings, issue FSM states and
// op classification helpers used by the issue logic, the MDU and the decoder.
package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUED = 2'd1,
        ST_BUSY   = 2'd2
    } md_state_e;

    localparam logic [15:0] STALL_CNT_MAX = 16'hFFFF;

    // Ops that launch a multi-cycle MDU operation.
    function automatic logic is_start_op(input logic [3:0] op);
        return (op >= 4'(OP_MULT)) && (op <= 4'(OP_DIVU));
    endfunction

    // Any op that talks to the MDU; codes above MTLO behave as nop.
    function automatic logic is_md_op(input logic [3:0] op);
        return (op >= 4'(OP_MULT)) && (op <= 4'(OP_MTLO));
    endfunction

endpackage

// File: rtl/mdu_issue.sv
// D->E issue stage for multiply/divide ops. Holds MD ops in D while the MDU
// is occupied (the MDU drops anything issued while busy), feeds the MDU from
// a registered E stage and counts the cycles spent stalling.
module mdu_issue
    import mdu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  d_mdop,
    input  logic [31:0] d_rs_val,
    input  logic [31:0] d_rt_val,
    input  logic        e_flush,
    input  logic        mdu_busy,
    output logic [3:0]  e_mdop,
    output logic [31:0] e_a,
    output logic [31:0] e_b,
    output logic        e_start,
    output logic        d_stall,
    output logic [15:0] stall_cnt
);

    md_state_e state_reg;
    logic      load_e;
    logic      start_load;

    // Hold an MD op in D while an op sits in ISSUED (busy not yet visible)
    // or the MDU reports busy; non-MD ops always flow.
    always_comb begin
        d_stall = is_md_op(d_mdop) &&
                  ((state_reg == ST_ISSUED) ||
                   ((state_reg == ST_BUSY) && mdu_busy));
    end

    assign load_e     = !d_stall && !e_flush;
    assign start_load = load_e && is_start_op(d_mdop);

    // Issue tracker; a flush never cancels an op that already left E.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start_load) state_reg <= ST_ISSUED;
                end
                ST_ISSUED: begin
                    state_reg <= ST_BUSY;
                end
                ST_BUSY: begin
                    if (!mdu_busy) state_reg <= start_load ? ST_ISSUED : ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    // E stage register: load the D op, or a bubble on stall or flush.
    always_ff @(posedge clk) begin
        if (reset || !load_e) begin
            e_mdop  <= 4'd0;
            e_a     <= 32'd0;
            e_b     <= 32'd0;
            e_start <= 1'b0;
        end else begin
            e_mdop  <= d_mdop;
            e_a     <= d_rs_val;
            e_b     <= d_rt_val;
            e_start <= is_start_op(d_mdop);
        end
    end

    // Saturating count of cycles the D stage was held for the MDU.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= 16'd0;
        end else if (d_stall && (stall_cnt != STALL_CNT_MAX)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_mdu_issue.sv
// Bench for mdu_issue: a simple MDU model (5-cycle mult, 10-cycle div busy)
// closes the loop, a reference model of the issue rules is compared every
// cycle, and directed scenarios pin stall lengths and results by hand.
module tb_mdu_issue;

    localparam logic [3:0] NOP = 4'd0, MULT = 4'd1, MULTU = 4'd2, DIV = 4'd3,
                           DIVU = 4'd4, MFHI = 4'd5, MFLO = 4'd6, MTHI = 4'd7,
                           MTLO = 4'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  d_mdop = 4'd0;
    logic [31:0] d_rs_val = 32'd0;
    logic [31:0] d_rt_val = 32'd0;
    logic        e_flush = 1'b0;
    logic        mdu_busy;
    logic [3:0]  e_mdop;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic        e_start;
    logic        d_stall;
    logic [15:0] stall_cnt;

    int n_checks = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    mdu_issue dut (
        .clk       (clk),
        .reset     (reset),
        .d_mdop    (d_mdop),
        .d_rs_val  (d_rs_val),
        .d_rt_val  (d_rt_val),
        .e_flush   (e_flush),
        .mdu_busy  (mdu_busy),
        .e_mdop    (e_mdop),
        .e_a       (e_a),
        .e_b       (e_b),
        .e_start   (e_start),
        .d_stall   (d_stall),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- MDU environment model ----------------
    logic [3:0]  busy_cnt;
    logic [31:0] hi, lo, rd_val;
    bit          hold_busy = 1'b0;
    assign mdu_busy = (busy_cnt != 4'd0) || hold_busy;

    always @(posedge clk) begin
        if (reset) begin
            busy_cnt <= 4'd0;
            hi <= 32'd0;
            lo <= 32'd0;
            rd_val <= 32'd0;
        end else begin
            if (busy_cnt != 4'd0) busy_cnt <= busy_cnt - 4'd1;
            if (e_start && busy_cnt == 4'd0) begin
                case (e_mdop)
                    MULT: begin
                        {hi, lo} <= 64'(longint'($signed(e_a)) * longint'($signed(e_b)));
                        busy_cnt <= 4'd5;
                    end
                    MULTU: begin
                        {hi, lo} <= 64'({32'd0, e_a}) * 64'({32'd0, e_b});
                        busy_cnt <= 4'd5;
                    end
                    DIV: begin
                        if (e_b != 0) begin
                            lo <= 32'($signed(e_a) / $signed(e_b));
                            hi <= 32'($signed(e_a) % $signed(e_b));
                        end
                        busy_cnt <= 4'd10;
                    end
                    default: begin
                        if (e_b != 0) begin
                            lo <= e_a / e_b;
                            hi <= e_a % e_b;
                        end
                        busy_cnt <= 4'd10;
                    end
                endcase
            end
            if (e_mdop == MFHI) rd_val <= hi;
            if (e_mdop == MFLO) rd_val <= lo;
            if (e_mdop == MTHI) hi <= e_a;
            if (e_mdop == MTLO) lo <= e_a;
        end
    end

    // ---------------- Reference model of the issue rules ----------------
    // An op is outstanding on its start cycle and for as long as the MDU
    // says busy; MD-class ops in D must wait it out.
    logic [3:0]  m_op;
    logic [31:0] m_a, m_b;
    logic        m_start;
    int          m_cnt;
    logic        exp_stall;
    assign exp_stall = (d_mdop >= 4'd1 && d_mdop <= 4'd8) && (m_start || mdu_busy);

    always @(posedge clk) begin
        if (reset) begin
            m_op <= 0; m_a <= 0; m_b <= 0; m_start <= 0; m_cnt <= 0;
        end else begin
            if (exp_stall) m_cnt <= (m_cnt >= 65535) ? 65535 : m_cnt + 1;
            if (exp_stall || e_flush) begin
                m_op <= 0; m_a <= 0; m_b <= 0; m_start <= 0;
            end else begin
                m_op <= d_mdop; m_a <= d_rs_val; m_b <= d_rt_val;
                m_start <= (d_mdop >= 4'd1 && d_mdop <= 4'd4);
            end
        end
    end

    // Per-cycle comparison against the model, plus protocol rules.
    logic prev_start = 1'b0;
    always @(negedge clk) begin
        if (chk_en) begin
            check("e_mdop", {28'd0, e_mdop}, {28'd0, m_op});
            check("e_a", e_a, m_a);
            check("e_b", e_b, m_b);
            check("e_start", {31'd0, e_start}, {31'd0, m_start});
            check("d_stall", {31'd0, d_stall}, {31'd0, exp_stall});
            check("stall_cnt", {16'd0, stall_cnt}, 32'(m_cnt));
            check("start_pulse_single", {31'd0, prev_start && e_start}, 32'd0);
            check("no_issue_while_busy", {31'd0, e_start && mdu_busy && !reset}, 32'd0);
        end
        prev_start = e_start;
    end

    // ---------------- Stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; d_mdop = NOP; d_rs_val = 0; d_rt_val = 0; e_flush = 0; hold_busy = 0;
        tick();
        tick();
        reset = 1'b0;
        chk_en = 1'b1;
    endtask

    task automatic set_d(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        d_mdop = op; d_rs_val = a; d_rt_val = b;
    endtask

    // Hold op in D until it is accepted; return the number of stalled cycles.
    task automatic hold_count(input logic [3:0] op, output int stalls);
        set_d(op, 32'd0, 32'd0);
        stalls = 0;
        for (int i = 0; i < 200; i++) begin
            if (!d_stall) begin
                tick();
                set_d(NOP, 0, 0);
                return;
            end
            stalls++;
            tick();
        end
        check("hold_timeout", 32'd1, 32'd0);
        set_d(NOP, 0, 0);
    endtask

    int stalls;
    int pulse_cnt, first_pulse, second_pulse;
    bit second_loaded;

    initial begin
        tick();
        do_reset();
        check("rst_e_mdop", {28'd0, e_mdop}, 32'd0);
        check("rst_e_start", {31'd0, e_start}, 32'd0);
        check("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // mult 3 * -2, then mflo
        set_d(MULT, 32'd3, 32'hFFFFFFFE);
        tick();
        hold_count(MFLO, stalls);
        check("mflo_stalls", 32'(stalls), 32'd6);
        tick(); tick();
        check("mflo_lo", rd_val, 32'hFFFFFFFA);
        $display("mult/mflo: stalls=%0d lo=%h", stalls, rd_val);

        // divu 7 / 2, then mfhi
        do_reset();
        set_d(DIVU, 32'd7, 32'd2);
        tick();
        hold_count(MFHI, stalls);
        check("mfhi_stalls", 32'(stalls), 32'd11);
        check("divu_stall_cnt", {16'd0, stall_cnt}, 32'd11);
        tick(); tick();
        check("mfhi_hi", rd_val, 32'd1);
        $display("divu/mfhi: stalls=%0d hi=%h cnt=%0d", stalls, rd_val, stall_cnt);

        // mult followed by non-MD ops every cycle
        do_reset();
        set_d(MULT, 32'd5, 32'd6);
        tick();
        for (int i = 1; i <= 10; i++) begin
            set_d(NOP, 32'(i * 17), ~32'(i));
            #1;
            check("alu_no_stall", {31'd0, d_stall}, 32'd0);
            tick();
            check("alu_e_a", e_a, 32'(i * 17));
        end
        $display("mult/alu stream: stall_cnt=%0d", stall_cnt);

        // back-to-back mult: six stall cycles between the two start pulses
        do_reset();
        set_d(MULT, 32'd3, 32'd4);
        tick();
        pulse_cnt = 0; first_pulse = -1; second_pulse = -1; second_loaded = 0;
        set_d(MULT, 32'd5, 32'd6);
        for (int k = 1; k <= 20; k++) begin
            if (e_start) begin
                pulse_cnt++;
                if (first_pulse < 0) first_pulse = k; else second_pulse = k;
            end
            if (!second_loaded && !d_stall) begin
                second_loaded = 1;
                tick();
                set_d(NOP, 0, 0);
            end else begin
                tick();
            end
        end
        check("b2b_pulses", 32'(pulse_cnt), 32'd2);
        check("b2b_gap", 32'(second_pulse - first_pulse), 32'd7);
        check("b2b_stall_cnt", {16'd0, stall_cnt}, 32'd6);
        $display("mult/mult: pulses=%0d at %0d and %0d", pulse_cnt, first_pulse, second_pulse);

        // flush on the same edge as div in D
        do_reset();
        set_d(DIV, 32'd9, 32'd3);
        e_flush = 1'b1;
        tick();
        e_flush = 1'b0;
        set_d(NOP, 0, 0);
        check("flush_e_start", {31'd0, e_start}, 32'd0);
        check("flush_e_mdop", {28'd0, e_mdop}, 32'd0);
        tick();
        set_d(MFLO, 0, 0);
        #1;
        check("flush_idle_nostall", {31'd0, d_stall}, 32'd0);
        tick();
        set_d(NOP, 0, 0);
        $display("flush div: e_start=%0d", e_start);

        // flush while an op is outstanding does not cancel it
        set_d(DIV, 32'd20, 32'd6);
        tick();
        set_d(MFLO, 0, 0);
        e_flush = 1'b1;
        tick();
        e_flush = 1'b0;
        hold_count(MFLO, stalls);
        check("flush_keep_stalls", 32'(stalls), 32'd10);
        tick(); tick();
        check("flush_keep_lo", rd_val, 32'd3);
        $display("div then flush: stalls=%0d lo=%h", stalls, rd_val);

        // reset while busy
        set_d(MULT, 32'd7, 32'd7);
        tick();
        set_d(NOP, 0, 0);
        tick(); tick(); tick();
        check("pre_reset_busy", {31'd0, mdu_busy}, 32'd1);
        set_d(MULT, 32'd9, 32'd9);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rstbusy_e_mdop", {28'd0, e_mdop}, 32'd0);
        check("rstbusy_e_a", e_a, 32'd0);
        check("rstbusy_e_start", {31'd0, e_start}, 32'd0);
        check("rstbusy_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        set_d(MFLO, 0, 0);
        #1;
        check("rstbusy_idle", {31'd0, d_stall}, 32'd0);
        tick();
        set_d(NOP, 0, 0);
        $display("reset in busy: e_mdop=%0d stall_cnt=%0d", e_mdop, stall_cnt);

        // counter saturation: MDU held busy far past 65535 stall cycles
        do_reset();
        set_d(MULT, 32'd1, 32'd1);
        tick();
        set_d(MFLO, 0, 0);
        tick();
        hold_busy = 1'b1;
        repeat (70000) tick();
        check("sat_stall_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
        check("sat_still_stall", {31'd0, d_stall}, 32'd1);
        $display("saturation: stall_cnt=%h", stall_cnt);
        hold_busy = 1'b0;
        hold_count(MFLO, stalls);
        tick(); tick();
        check("sat_lo", rd_val, 32'd1);

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
